data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameters SHALL be:
- BUS_DATA_WIDTH, default 64, system-bus data width.
- BUS_TAG_WIDTH, default 13, system-bus tag width.
REQ-002 Clock and reset SHALL be clock clk; reset reset, synchronous, active-high.
REQ-003 Ports after clk/reset (name, direction, width, meaning) SHALL be:
- stackptr in 64: stack pointer, informational only, no functional effect.
- bus_reqcyc out 1: bus request valid.
- bus_reqack in 1: bus request accepted.
- bus_req out BUS_DATA_WIDTH: request address.
- bus_reqtag out BUS_TAG_WIDTH: request tag.
- bus_respcyc in 1: response beat valid.
- bus_respack out 1: response beat consumed.
- bus_resp in BUS_DATA_WIDTH: response data beat.
- bus_resptag in BUS_TAG_WIDTH: response tag, ignored.
- mem_active in 1: current op is a load or store.
- load in 1: 1 = load, 0 = store.
- in_addr in 64: byte address.
- in_data in 64: store data, right-aligned.
- ldst_size in 8: access bytes, one of 1, 2, 4 or 8.
- ldst_unsign in 1: zero-extend load.
- memwb_loadeddata out 64: extended load result.
- load_str_done out 1: op completes this cycle.
- MEMEX_stall out 1: pipeline must hold inputs.
- dataselect out 1: result comes from memory.
- MEMWB_pend_write out 1: store to commit.
- MEMWB_size out 4: store bytes.
- MEMWB_value out 64: store data.
- MEMWB_addr out 64: store address.
- dcache_busreq out 1: arbiter request.
- dcache_busidle out 1: cache not using bus.
- dcache_busgrant in 1: arbiter grant.

Function
REQ-004 Organisation SHALL be direct-mapped, 512 sets, 64-byte lines (8 beats): offset addr[5:0], index addr[14:6], tag addr[63:15], one valid bit per set.
REQ-005 States SHALL be IDLE, ARB, REQ and FILL.
REQ-006 Hit SHALL mean mem_active=1, load=1, valid[index] set and tag match; it completes combinationally the same cycle with MEMEX_stall=0 and load_str_done=1.
REQ-007 Load data SHALL be bytes [offset+size-1:offset] of the line, sign-extended when ldst_unsign=0 and zero-extended when 1; accesses never cross a line.
REQ-008 Load miss in IDLE SHALL assert MEMEX_stall=1 and go to ARB; MEMEX_stall stays 1 in ARB, REQ and FILL.
REQ-009 ARB SHALL assert dcache_busreq=1 and go to REQ on dcache_busgrant=1.
REQ-010 REQ SHALL drive bus_reqcyc=1, bus_req={addr[63:6],6'b0} and bus_reqtag=13'h1100 (read, memory), held until bus_reqack=1, then go to FILL.
REQ-011 FILL SHALL drive bus_respack=1 for each bus_respcyc beat and write beat k into word k; after beat 7 it sets valid and tag, returns to IDLE and releases busreq.
REQ-012 The op SHALL then hit in IDLE on the next cycle, with MEMEX_stall=0 that cycle.
REQ-013 Store (mem_active=1, load=0) SHALL be write-through, no-write-allocate, and never stall: MEMWB_pend_write=1, MEMWB_size=ldst_size[3:0], MEMWB_value=in_data, MEMWB_addr=in_addr, load_str_done=1.
REQ-014 On a store hit, the addressed bytes of the line SHALL be updated at the clock edge.
REQ-015 mem_active=0 SHALL complete immediately with no stall and pend_write=0.
REQ-016 dataselect SHALL be mem_active&load; memwb_loadeddata SHALL be 0 when not a load hit.
REQ-017 dcache_busidle SHALL be 1 exactly in IDLE.
REQ-018 In IDLE, bus_reqcyc and bus_respack SHALL be 0.
REQ-019 In-flight input changes SHALL be ignored; the fill uses the address latched at the miss.

Reset
REQ-020 Reset SHALL, at the clock edge, set state=IDLE, clear all valid bits and the beat counter, and deassert every bus and arbiter request.
REQ-021 Outputs SHALL be 0 after reset except dcache_busidle=1.
REQ-022 Reset SHALL override everything, including mid-fill; the partial line stays invalid.

Structure
REQ-023 A shared package SHALL hold the state enum, the tag constant 13'h1100, and the line/index/offset widths.
REQ-024 One sub-module, dcache_extract, SHALL perform byte-lane load extraction and sign/zero extension.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Load 8B at 0x1000 after reset -> stall, busreq, then bus_req=0x1000 with tag 0x1100; 8 beats 0..7 -> stall drops, loadeddata=0.
- Load 1B signed at 0x1008, word 0x80 -> 0xFFFFFFFFFFFFFF80 with no stall; unsigned -> 0x80.
- Store 4B 0xDEADBEEF at 0x1010 (hit) -> pend_write=1, size=4, addr=0x1010; later 4B unsigned load -> 0xDEADBEEF.
- Store to uncached 0x9000 -> pend_write=1, no stall, no bus activity.
- Conflict load at 0x9000 (same index as 0x1000) -> refill; subsequent load at 0x1000 misses again.
- Reset asserted during FILL beat 3 -> IDLE, busidle=1; reload of the same address misses.

Source files
------------

// File: rtl/data_cache_pkg.sv
// data_cache_pkg: shared geometry, bus tag and FSM state for the data cache
package data_cache_pkg;
  localparam int OFF_W = 6;
  localparam int IDX_W = 9;
  localparam int TAG_W = 64 - OFF_W - IDX_W;
  localparam int SETS = 1 << IDX_W;
  localparam int LINE_W = 8 << OFF_W;
  localparam int BEATS = LINE_W / 64;
  localparam int BEAT_W = $clog2(BEATS);
  localparam logic [12:0] REQ_TAG = 13'h1100;
  typedef enum logic [1:0] {IDLE, ARB, REQ, FILL} state_e;
endpackage

// File: rtl/dcache_extract.sv
// dcache_extract: pick the addressed bytes out of a line and sign/zero-extend them
module dcache_extract
  import data_cache_pkg::*;
(
  input  logic [LINE_W-1:0] line_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [7:0]        size_i,
  input  logic              unsign_i,
  output logic [63:0]       data_o
);
  logic [63:0] w;
  // Align the first byte to bit 0, then trim to the access width and extend
  always_comb begin
    w = 64'(line_i >> {off_i, 3'b000});
    data_o = size_i == 8'd1 ? (unsign_i ? {56'b0, w[7:0]} : {{56{w[7]}}, w[7:0]}) :
             size_i == 8'd2 ? (unsign_i ? {48'b0, w[15:0]} : {{48{w[15]}}, w[15:0]}) :
             size_i == 8'd4 ? (unsign_i ? {32'b0, w[31:0]} : {{32{w[31]}}, w[31:0]}) : w;
  end
endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped write-through load/store cache with an 8-beat line fill
module data_cache
  import data_cache_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH = 13
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               stackptr,
  output logic                      bus_reqcyc,
  input  logic                      bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_respcyc,
  output logic                      bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      mem_active,
  input  logic                      load,
  input  logic [63:0]               in_addr,
  input  logic [63:0]               in_data,
  input  logic [7:0]                ldst_size,
  input  logic                      ldst_unsign,
  output logic [63:0]               memwb_loadeddata,
  output logic                      load_str_done,
  output logic                      MEMEX_stall,
  output logic                      dataselect,
  output logic                      MEMWB_pend_write,
  output logic [3:0]                MEMWB_size,
  output logic [63:0]               MEMWB_value,
  output logic [63:0]               MEMWB_addr,
  output logic                      dcache_busreq,
  output logic                      dcache_busidle,
  input  logic                      dcache_busgrant
);
  state_e state_q, state_d;
  logic [SETS-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [SETS];
  logic [LINE_W-1:0] data_q [SETS];
  logic [BEAT_W-1:0] cnt_q;
  logic [63-OFF_W:0] line_q;
  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx, fill_idx;
  logic [TAG_W-1:0] tag;
  logic idle, tag_hit, hit, miss, store, store_hit, beat, last_beat;
  logic [63:0] ext;
  logic unused_ok;

  assign off = in_addr[OFF_W-1:0];
  assign idx = in_addr[OFF_W +: IDX_W];
  assign tag = in_addr[63 -: TAG_W];
  assign fill_idx = line_q[IDX_W-1:0];
  assign idle = state_q == IDLE;
  assign tag_hit = valid_q[idx] && tag_q[idx] == tag;
  assign hit = idle && mem_active && load && tag_hit;
  assign miss = idle && mem_active && load && !tag_hit;
  assign store = idle && mem_active && !load;
  assign store_hit = store && tag_hit;
  assign beat = state_q == FILL && bus_respcyc;
  assign last_beat = beat && cnt_q == BEAT_W'(BEATS - 1);
  assign unused_ok = ^{stackptr, bus_resptag};

  dcache_extract u_extract (
    .line_i  (data_q[idx]),
    .off_i   (off),
    .size_i  (ldst_size),
    .unsign_i(ldst_unsign),
    .data_o  (ext)
  );

  // FSM state register
  always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;

  // Miss -> arbitrate -> request -> collect beats -> back to idle
  always_comb begin
    state_d = (state_q == IDLE && miss) ? ARB :
              (state_q == ARB && dcache_busgrant) ? REQ :
              (state_q == REQ && bus_reqack) ? FILL :
              last_beat ? IDLE : state_q;
  end

  // Beat counter and valid bits; a line becomes valid only once its last beat lands
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      cnt_q <= '0;
    end else begin
      if (beat) cnt_q <= cnt_q + 1'b1;
      if (last_beat) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Latch the missing line address so later input changes cannot redirect the fill
  always_ff @(posedge clk) if (miss) line_q <= in_addr[63:OFF_W];

  // Tag and data arrays: fill beats, or byte-lane merge of a store hit
  always_ff @(posedge clk) begin
    if (last_beat) tag_q[fill_idx] <= line_q[63-OFF_W -: TAG_W];
    if (beat) data_q[fill_idx][int'(cnt_q)*64 +: 64] <= 64'(bus_resp);
    else if (store_hit)
      for (int b = 0; b < 8; b++)
        if (b < int'(ldst_size)) data_q[idx][(int'(off) + b)*8 +: 8] <= in_data[b*8 +: 8];
  end

  // Pipeline handshake and bus outputs decoded from state
  always_comb begin
    MEMEX_stall = !idle || miss;
    load_str_done = hit || store;
    dataselect = mem_active && load;
    memwb_loadeddata = hit ? ext : '0;
    MEMWB_pend_write = store;
    MEMWB_size = store ? ldst_size[3:0] : '0;
    MEMWB_value = store ? in_data : '0;
    MEMWB_addr = store ? in_addr : '0;
    dcache_busreq = !idle;
    dcache_busidle = idle;
    bus_reqcyc = state_q == REQ;
    bus_req = state_q == REQ ? BUS_DATA_WIDTH'({line_q, {OFF_W{1'b0}}}) : '0;
    bus_reqtag = state_q == REQ ? BUS_TAG_WIDTH'(REQ_TAG) : '0;
    bus_respack = beat;
  end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed vectors and fill sequences for data_cache
module tb_data_cache;
  logic clk, reset;
  logic [63:0] stackptr;
  logic bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
  logic [63:0] bus_req, bus_resp;
  logic [12:0] bus_reqtag, bus_resptag;
  logic mem_active, load, ldst_unsign;
  logic [63:0] in_addr, in_data;
  logic [7:0] ldst_size;
  logic [63:0] memwb_loadeddata;
  logic load_str_done, MEMEX_stall, dataselect, MEMWB_pend_write;
  logic [3:0] MEMWB_size;
  logic [63:0] MEMWB_value, MEMWB_addr;
  logic dcache_busreq, dcache_busidle, dcache_busgrant;
  int n_chk = 0;
  int n_fail = 0;

  data_cache dut (
    .clk(clk), .reset(reset), .stackptr(stackptr),
    .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_respcyc(bus_respcyc), .bus_respack(bus_respack), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .mem_active(mem_active), .load(load), .in_addr(in_addr), .in_data(in_data),
    .ldst_size(ldst_size), .ldst_unsign(ldst_unsign), .memwb_loadeddata(memwb_loadeddata),
    .load_str_done(load_str_done), .MEMEX_stall(MEMEX_stall), .dataselect(dataselect),
    .MEMWB_pend_write(MEMWB_pend_write), .MEMWB_size(MEMWB_size), .MEMWB_value(MEMWB_value),
    .MEMWB_addr(MEMWB_addr), .dcache_busreq(dcache_busreq), .dcache_busidle(dcache_busidle),
    .dcache_busgrant(dcache_busgrant)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic act, ld;
    logic [63:0] addr, data;
    logic [7:0] size;
    logic uns, e_pend;
    logic [63:0] e_ld;
  } vec_t;
  vec_t v[15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Load miss on address a, serve the fill with beat k = seed + k*0x80; optionally reset at beat rst_beat
  task automatic miss_fill(input logic [63:0] a, input logic [63:0] seed, input int rst_beat);
    @(negedge clk);
    mem_active = 1; load = 1; in_addr = a; ldst_size = 8; ldst_unsign = 0;
    #1;
    chk("miss stall", MEMEX_stall, 1);
    chk("miss done", load_str_done, 0);
    chk("miss data", memwb_loadeddata, 0);
    chk("miss busreq", dcache_busreq, 0);
    @(negedge clk);
    in_addr = ~a;
    #1;
    chk("arb busreq", dcache_busreq, 1);
    chk("arb busidle", dcache_busidle, 0);
    chk("arb reqcyc", bus_reqcyc, 0);
    chk("arb stall", MEMEX_stall, 1);
    dcache_busgrant = 1;
    @(negedge clk);
    dcache_busgrant = 0;
    #1;
    chk("req reqcyc", bus_reqcyc, 1);
    chk("req addr", bus_req, a & ~64'h3F);
    chk("req tag", bus_reqtag, 13'h1100);
    @(negedge clk);
    #1;
    chk("req held", bus_reqcyc, 1);
    bus_reqack = 1;
    @(negedge clk);
    bus_reqack = 0;
    #1;
    chk("fill reqcyc", bus_reqcyc, 0);
    chk("fill noack", bus_respack, 0);
    for (int k = 0; k < 8; k++) begin
      bus_respcyc = 1;
      bus_resp = seed + 64'(k) * 64'h80;
      #1;
      chk($sformatf("beat%0d ack", k), bus_respack, 1);
      chk($sformatf("beat%0d stall", k), MEMEX_stall, 1);
      if (k == rst_beat) reset = 1;
      @(negedge clk);
      if (reset) begin
        reset = 0; bus_respcyc = 0; mem_active = 0; in_addr = a;
        #1;
        chk("rst busidle", dcache_busidle, 1);
        chk("rst busreq", dcache_busreq, 0);
        chk("rst reqcyc", bus_reqcyc, 0);
        chk("rst respack", bus_respack, 0);
        chk("rst stall", MEMEX_stall, 0);
        return;
      end
    end
    bus_respcyc = 0;
    in_addr = a;
    #1;
    chk("after fill stall", MEMEX_stall, 0);
    chk("after fill done", load_str_done, 1);
    chk("after fill busidle", dcache_busidle, 1);
    chk("after fill data", memwb_loadeddata, seed);
  endtask

  initial begin
    v[0]  = '{1, 1, 64'h1008, 0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FF80};
    v[1]  = '{1, 1, 64'h1008, 0, 1, 1, 0, 64'h80};
    v[2]  = '{1, 1, 64'h1008, 0, 2, 0, 0, 64'h80};
    v[3]  = '{1, 1, 64'h1018, 0, 8, 0, 0, 64'h180};
    v[4]  = '{1, 1, 64'h1038, 0, 2, 0, 0, 64'h380};
    v[5]  = '{1, 1, 64'h103F, 0, 1, 0, 0, 64'h0};
    v[6]  = '{1, 0, 64'h1010, 64'hDEADBEEF, 4, 0, 1, 64'h0};
    v[7]  = '{1, 1, 64'h1010, 0, 4, 1, 0, 64'hDEADBEEF};
    v[8]  = '{1, 1, 64'h1010, 0, 4, 0, 0, 64'hFFFF_FFFF_DEAD_BEEF};
    v[9]  = '{1, 0, 64'h1017, 64'h7F, 1, 0, 1, 64'h0};
    v[10] = '{1, 1, 64'h1010, 0, 8, 0, 0, 64'h7F00_0000_DEAD_BEEF};
    v[11] = '{1, 0, 64'h9000, 64'h0123_4567_89AB_CDEF, 8, 0, 1, 64'h0};
    v[12] = '{1, 1, 64'h1000, 0, 8, 0, 0, 64'h0};
    v[13] = '{0, 0, 64'h1010, 0, 4, 0, 0, 64'h0};
    v[14] = '{1, 1, 64'h1016, 0, 2, 1, 0, 64'h7F00};

    stackptr = 64'h7FFF_0000; bus_reqack = 0; bus_respcyc = 0; bus_resp = 0; bus_resptag = 0;
    mem_active = 0; load = 0; in_addr = 0; in_data = 0; ldst_size = 0; ldst_unsign = 0;
    dcache_busgrant = 0; reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    #1;
    chk("reset busidle", dcache_busidle, 1);
    chk("reset busreq", dcache_busreq, 0);
    chk("reset stall", MEMEX_stall, 0);
    chk("reset reqcyc", bus_reqcyc, 0);
    chk("reset respack", bus_respack, 0);
    chk("reset pend", MEMWB_pend_write, 0);
    chk("reset data", memwb_loadeddata, 0);
    chk("reset dsel", dataselect, 0);

    miss_fill(64'h1000, 64'h0, 8);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      mem_active = v[i].act; load = v[i].ld; in_addr = v[i].addr; in_data = v[i].data;
      ldst_size = v[i].size; ldst_unsign = v[i].uns;
      #1;
      chk($sformatf("row%0d stall", i), MEMEX_stall, 0);
      chk($sformatf("row%0d done", i), load_str_done, v[i].act);
      chk($sformatf("row%0d pend", i), MEMWB_pend_write, v[i].e_pend);
      chk($sformatf("row%0d data", i), memwb_loadeddata, v[i].e_ld);
      chk($sformatf("row%0d dsel", i), dataselect, v[i].act & v[i].ld);
      chk($sformatf("row%0d busidle", i), dcache_busidle, 1);
      chk($sformatf("row%0d busreq", i), dcache_busreq, 0);
      chk($sformatf("row%0d reqcyc", i), bus_reqcyc, 0);
      if (v[i].e_pend) begin
        chk($sformatf("row%0d size", i), MEMWB_size, v[i].size[3:0]);
        chk($sformatf("row%0d value", i), MEMWB_value, v[i].data);
        chk($sformatf("row%0d addr", i), MEMWB_addr, v[i].addr);
      end
    end

    miss_fill(64'h9000, 64'h1111_0000_0000_0000, 8);
    miss_fill(64'h1000, 64'h0, 8);
    @(negedge clk);
    in_addr = 64'h1010; ldst_size = 4; ldst_unsign = 1;
    #1;
    chk("refill store gone", memwb_loadeddata, 64'h100);
    chk("refill stall", MEMEX_stall, 0);

    miss_fill(64'h2000, 64'hA5, 3);
    miss_fill(64'h2000, 64'hA5, 8);
    @(negedge clk);
    in_addr = 64'h2008;
    #1;
    chk("reload word1", memwb_loadeddata, 64'h125);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
